// File: rtl/read_iq_multi.sv
// Raw IQ word reader: pops 32-bit sample words and writes I/Q pairs to two FIFOs in lockstep.
// Handles S16 (one pair per word) and U8 offset-binary (two pairs per word) formats.
module read_iq_multi #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUANT_BITS  = 10,
  parameter int U8_SHIFT    = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  output logic                   inA_rd_en,
  input  logic                   inA_empty,
  input  logic [31:0]            inA_dout,
  output logic                   out_wr_en,
  input  logic                   out_full,
  output logic [DATA_WIDTH-1:0]  out_din,
  output logic                   out_wr_en_2,
  input  logic                   out_full_2,
  output logic [DATA_WIDTH-1:0]  out_din_2,
  output logic [COUNT_WIDTH-1:0] sample_count
);

  typedef enum logic [1:0] {LOAD, EMIT0, EMIT1} state_t;

  state_t      state, state_nxt;
  logic [31:0] word_r;
  logic        mode_r;
  logic        pop, wr, out_ok;
  logic [7:0]  b0, b1, b2, b3;
  logic signed [16:0] i_raw, q_raw;

  // b0 is the first byte of the file stream, held in the top byte of the word
  assign b0 = word_r[31:24];
  assign b1 = word_r[23:16];
  assign b2 = word_r[15:8];
  assign b3 = word_r[7:0];

  function automatic logic signed [16:0] u8_centre(input logic [7:0] b);
    return $signed({9'd0, b}) - 17'sd128;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [16:0] s, input logic u8);
    logic signed [DATA_WIDTH-1:0] e;
    e = DATA_WIDTH'(s);
    return u8 ? (e <<< (QUANT_BITS + U8_SHIFT)) : (e <<< QUANT_BITS);
  endfunction

  always_comb begin
    i_raw = '0;
    q_raw = '0;
    if (!mode_r) begin
      i_raw = $signed({b1[7], b1, b0});
      q_raw = $signed({b3[7], b3, b2});
    end else if (state == EMIT1) begin
      i_raw = u8_centre(b2);
      q_raw = u8_centre(b3);
    end else begin
      i_raw = u8_centre(b0);
      q_raw = u8_centre(b1);
    end
  end

  assign out_din   = reset ? scale(i_raw, mode_r) : '0;
  assign out_din_2 = reset ? scale(q_raw, mode_r) : '0;

  // Pop of the next word overlaps the last write of the current one for full throughput
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr        = 1'b0;
    out_ok    = !out_full && !out_full_2;
    case (state)
      LOAD: begin
        if (!inA_empty) begin
          pop       = 1'b1;
          state_nxt = EMIT0;
        end
      end
      EMIT0: begin
        if (out_ok) begin
          wr = 1'b1;
          if (mode_r) begin
            state_nxt = EMIT1;
          end else if (!inA_empty) begin
            pop       = 1'b1;
            state_nxt = EMIT0;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      EMIT1: begin
        if (out_ok) begin
          wr = 1'b1;
          if (!inA_empty) begin
            pop       = 1'b1;
            state_nxt = EMIT0;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
    if (!reset) begin
      pop = 1'b0;
      wr  = 1'b0;
    end
  end

  assign inA_rd_en   = pop;
  assign out_wr_en   = wr;
  assign out_wr_en_2 = wr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= LOAD;
      word_r       <= '0;
      mode_r       <= 1'b0;
      sample_count <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        word_r <= inA_dout;
        mode_r <= mode;
      end
      if (wr) sample_count <= sample_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_read_iq_multi.sv
// Directed bench for read_iq_multi: FIFO-modelled input, logged writes checked against hand-computed pairs.
module tb_read_iq_multi;

  logic        clock, reset, mode;
  logic        inA_rd_en, inA_empty;
  logic [31:0] inA_dout;
  logic        out_wr_en, out_full, out_wr_en_2, out_full_2;
  logic [31:0] out_din, out_din_2, sample_count;

  read_iq_multi dut (
    .clock(clock), .reset(reset), .mode(mode),
    .inA_rd_en(inA_rd_en), .inA_empty(inA_empty), .inA_dout(inA_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .out_wr_en_2(out_wr_en_2), .out_full_2(out_full_2), .out_din_2(out_din_2),
    .sample_count(sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] in_q[$];
  longint      oi[$], oq[$];
  int          wc[$], rc[$];
  int          cyc_n;
  int          wr_mismatch;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    oi.delete(); oq.delete(); wc.delete(); rc.delete();
    cyc_n = 0;
    wr_mismatch = 0;
  endtask

  // One clock cycle: present FIFO head, sample strobes mid-cycle, advance past the edge
  task automatic cyc();
    logic rd;
    inA_empty = (in_q.size() == 0);
    inA_dout  = inA_empty ? 32'd0 : in_q[0];
    #1;
    rd = inA_rd_en;
    if (out_wr_en !== out_wr_en_2) wr_mismatch++;
    if (rd) rc.push_back(cyc_n);
    if (out_wr_en) begin
      wc.push_back(cyc_n);
      oi.push_back(longint'($signed(out_din)));
      oq.push_back(longint'($signed(out_din_2)));
    end
    @(posedge clock);
    #1;
    if (rd && in_q.size() > 0) void'(in_q.pop_front());
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; out_full = 1'b0; out_full_2 = 1'b0;
    inA_empty = 1'b1; inA_dout = '0;
    @(posedge clock); #1;

    // Reset: non-empty input must not be popped while reset is held
    clear_log();
    in_q.push_back(32'h3412CDAB);
    run(2);
    chk("rst_pops", rc.size(), 0);
    chk("rst_writes", wc.size(), 0);
    chk("rst_din", longint'(out_din), 0);
    chk("rst_din2", longint'(out_din_2), 0);
    chk("rst_count", longint'(sample_count), 0);
    in_q.delete();
    reset = 1'b1;

    // 1: S16 single word
    clear_log();
    mode = 1'b0;
    in_q.push_back(32'h3412CDAB);
    run(4);
    chk("s16_writes", wc.size(), 1);
    chk("s16_pops", rc.size(), 1);
    if (wc.size() >= 1) begin
      chk("s16_i", oi[0], 4771840);
      chk("s16_q", oq[0], -22072320);
      chk("s16_latency", wc[0] - rc[0], 1);
    end
    chk("s16_count", longint'(sample_count), 1);

    // 2: U8 word gives two back-to-back pairs from one pop
    clear_log();
    mode = 1'b1;
    in_q.push_back(32'hFF00807F);
    run(5);
    chk("u8_writes", wc.size(), 2);
    chk("u8_pops", rc.size(), 1);
    if (wc.size() >= 2) begin
      chk("u8_p0_i", oi[0], 33292288);
      chk("u8_p0_q", oq[0], -33554432);
      chk("u8_p1_i", oi[1], 0);
      chk("u8_p1_q", oq[1], -262144);
      chk("u8_back2back", wc[1] - wc[0], 1);
    end
    chk("u8_count", longint'(sample_count), 3);

    // 3: S16 throughput, four words preloaded
    clear_log();
    mode = 1'b0;
    in_q.push_back(32'h0100FF7F);
    in_q.push_back(32'h00800080);
    in_q.push_back(32'h3412CDAB);
    in_q.push_back(32'hFFFF0000);
    run(7);
    chk("tp_pops", rc.size(), 4);
    chk("tp_writes", wc.size(), 4);
    if (rc.size() == 4 && wc.size() == 4) begin
      chk("tp_pop_span", rc[3] - rc[0], 3);
      chk("tp_first_wr", wc[0] - rc[0], 1);
      chk("tp_wr_span", wc[3] - wc[0], 3);
      chk("tp_w0_i", oi[0], 1024);
      chk("tp_w0_q", oq[0], 33553408);
      chk("tp_w1_i", oi[1], -33554432);
      chk("tp_w1_q", oq[1], -33554432);
      chk("tp_w3_i", oi[3], -1024);
      chk("tp_w3_q", oq[3], 0);
    end
    chk("tp_count", longint'(sample_count), 7);

    // 4: Q FIFO full for 5 cycles while a word is held in EMIT0
    clear_log();
    out_full_2 = 1'b1;
    in_q.push_back(32'h3412CDAB);
    in_q.push_back(32'h0100FF7F);
    run(1);
    run(5);
    chk("bp_stall_writes", wc.size(), 0);
    chk("bp_stall_pops", rc.size(), 1);
    chk("bp_hold_i", longint'($signed(out_din)), 4771840);
    chk("bp_hold_q", longint'($signed(out_din_2)), -22072320);
    out_full_2 = 1'b0;
    run(1);
    chk("bp_release_wr", wc.size(), 1);
    run(3);
    chk("bp_writes", wc.size(), 2);
    if (wc.size() == 2) begin
      chk("bp_i0", oi[0], 4771840);
      chk("bp_i1", oi[1], 1024);
    end
    chk("bp_count", longint'(sample_count), 9);

    // 5: mode flips while an S16 word is held; next word decodes as U8
    clear_log();
    mode = 1'b0;
    out_full = 1'b1;
    in_q.push_back(32'h3412CDAB);
    in_q.push_back(32'hFF00807F);
    run(1);
    mode = 1'b1;
    run(2);
    out_full = 1'b0;
    run(5);
    chk("ms_writes", wc.size(), 3);
    if (wc.size() == 3) begin
      chk("ms_s16_i", oi[0], 4771840);
      chk("ms_s16_q", oq[0], -22072320);
      chk("ms_u8_i0", oi[1], 33292288);
      chk("ms_u8_q1", oq[2], -262144);
    end
    chk("ms_count", longint'(sample_count), 12);

    // 6: reset while U8 pair 1 is pending
    clear_log();
    mode = 1'b1;
    in_q.push_back(32'hFF00807F);
    run(2);
    chk("rm_pre_writes", wc.size(), 1);
    reset = 1'b0;
    run(2);
    chk("rm_rst_writes", wc.size(), 1);
    reset = 1'b1;
    chk("rm_count_zero", longint'(sample_count), 0);
    chk("rm_din_zero", longint'(out_din), 0);
    clear_log();
    mode = 1'b0;
    in_q.push_back(32'h3412CDAB);
    run(4);
    chk("rm_pops", rc.size(), 1);
    if (rc.size() == 1) chk("rm_pop_immediate", rc[0], 0);
    chk("rm_writes", wc.size(), 1);
    if (wc.size() == 1) begin
      chk("rm_i", oi[0], 4771840);
      chk("rm_q", oq[0], -22072320);
    end
    chk("rm_count", longint'(sample_count), 1);
    chk("wr_strobe_lockstep", wr_mismatch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/read_iq_multi.md
Name: read_iq_multi

Overview:
- Parametrised successor of the current IQ reader. Pops packed 32-bit raw-sample words from the input FIFO, splits each word into I and Q, removes the format offset, scales to fixed point and writes I and Q in lockstep to two output FIFOs.
- Adds a second input format: 8-bit unsigned offset-binary IQ, RTL-SDR style, carrying two IQ pairs per word.
- Adds a per-word mode latch, full-throughput pop/emit overlap and a running pair counter.
- Sits between the raw-sample FIFO and the channel filter stage.

Parameters:
- DATA_WIDTH, 32, width of out_din/out_din_2 (signed, two's complement).
- QUANT_BITS, 10, left shift applied to every decoded sample.
- U8_SHIFT, 8, extra left shift in U8 mode so that U8 full scale matches S16 full scale.
- COUNT_WIDTH, 32, width of sample_count.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- mode  in  1  0 = S16 (one signed 16-bit little-endian IQ pair per word), 1 = U8 (two unsigned 8-bit IQ pairs per word).
- inA_rd_en  out  1  pop strobe to the input FIFO.
- inA_empty  in  1  input FIFO empty.
- inA_dout  in  32  input FIFO head word (first-word-fall-through: valid whenever inA_empty = 0).
- out_wr_en  out  1  I FIFO write strobe.
- out_full  in  1  I FIFO full.
- out_din  out  DATA_WIDTH  I sample.
- out_wr_en_2  out  1  Q FIFO write strobe.
- out_full_2  in  1  Q FIFO full.
- out_din_2  out  DATA_WIDTH  Q sample.
- sample_count  out  COUNT_WIDTH  IQ pairs written since reset; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Byte numbering: b0 = inA_dout[31:24] (first file byte), b1 = [23:16], b2 = [15:8], b3 = [7:0].
- S16 decoding: I = signed {b1,b0}; Q = signed {b3,b2}.
- U8 decoding: pair 0 is I = b0-128, Q = b1-128; pair 1 is I = b2-128, Q = b3-128. Each value is a 9-bit signed result.
- Scaling: out = sign-extend(sample) << QUANT_BITS, plus << U8_SHIFT in U8 mode, truncated to DATA_WIDTH. No saturation is applied at the defaults.
- FSM states: LOAD, EMIT0, EMIT1.
  - LOAD: when inA_empty = 0, assert inA_rd_en, capture the word into word_r and mode into mode_r, then go to EMIT0. Otherwise stay.
  - EMIT0: write pair 0 when out_full = 0 AND out_full_2 = 0.
    - If mode_r = U8, go to EMIT1.
    - If mode_r = S16 and inA_empty = 0, pop and capture the next word in the same cycle and stay in EMIT0.
    - If mode_r = S16 and inA_empty = 1, go to LOAD.
  - EMIT1: write pair 1 under the same full condition. Then apply the same pop-or-LOAD rule as EMIT0, with the next state EMIT0 on a pop.
- Write strobes: out_wr_en and out_wr_en_2 are combinational, always equal, and asserted only in EMIT0/EMIT1 when neither output FIFO is full. out_din and out_din_2 are combinational from word_r, mode_r and the current state.
- Backpressure: either full flag stalls both outputs; the held pair, state and word_r are unchanged. inA_rd_en is never asserted during a stall.
- Latency: a word popped in cycle N has pair 0 written in cycle N+1 at the earliest.
- Throughput: 1 pair/cycle sustained in both modes (S16: 1 word/cycle; U8: 1 word/2 cycles).
- mode is sampled only at word capture. A change of mode mid-word takes effect on the next word.
- sample_count increments by 1 on each cycle in which out_wr_en = 1.
- Reset (reset = 0 on a rising edge), including mid-word:
  - state = LOAD, word_r = 0, mode_r = 0, sample_count = 0.
  - All strobes are 0 and out_din/out_din_2 = 0 while reset is held.
  - Any held pair is discarded.

Test Plan:
1. S16, mode = 0, word 0x3412CDAB -> one write with out_din = 4771840 and out_din_2 = -22072320; sample_count = 1.
2. U8, mode = 1, word 0xFF00807F -> two consecutive writes: (33292288, -33554432), then (0, -262144); sample_count = 2; one inA_rd_en pulse.
3. Throughput: four S16 words preloaded, outputs never full -> 4 inA_rd_en pulses on cycles N..N+3 and writes on N+1..N+4 with no bubbles.
4. Backpressure: out_full_2 = 1 for 5 cycles during EMIT0 -> no write strobes, no pops, outputs stable. The pair is written on the first cycle after the release; no duplicate and no loss.
5. Mode switch: mode toggled to 1 while an S16 word is held in EMIT0 -> that word is emitted as S16; the next word is decoded as U8.
6. Reset mid-U8 in EMIT1 -> pair 1 is never written; after release sample_count = 0 and the FSM is in LOAD. The next word (0x3412CDAB, S16) decodes as in scenario 1.
